// File: rtl/cmp_sort_pkg.sv
// cmp_sort_pkg: shared types and constants for the comparator-based sort engine
//   state_e  : engine phases LOAD / SORT / DRAIN
//   DATA_W   : width of each sorted value
//   ptr_w()  : pointer width for a block of the given depth
package cmp_sort_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mag_cmp4.sv
// mag_cmp4: combinational 4-bit unsigned magnitude comparator
//   a, b : operands
//   lt   : a < b
//   gt   : a > b
//   eq   : a == b  (exactly one of lt/gt/eq is high)
module mag_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       gt,
    output logic       eq
);

    assign lt = a < b;
    assign gt = a > b;
    assign eq = a == b;

endmodule

// File: rtl/cmp_sort_engine.sv
// cmp_sort_engine: loads DEPTH 4-bit values, bubble-sorts them with one shared comparator, streams them out ascending
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, ready only in LOAD
//   in_data             : value to store
//   out_valid/out_ready : output handshake, valid only in DRAIN
//   out_data            : sorted value, 0 when out_valid is low
//   busy                : high in SORT and DRAIN
//   cmp_count           : comparisons in the most recent sort
module cmp_sort_engine
    import cmp_sort_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [7:0]        cmp_count
);

    localparam int PW = ptr_w(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t       LAST     = ptr_t'(DEPTH - 1);
    localparam ptr_t       IDX_END  = ptr_t'(DEPTH - 2);
    localparam logic [3:0] PASS_END = 4'(DEPTH - 2);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              idx_q, idx_d;
    logic [3:0]        pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic [7:0]        cnt_q, cnt_d;

    ptr_t              idx_nx;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_lt, cmp_gt, cmp_eq;
    logic              cmp_unused;
    logic              sw_now;

    assign idx_nx = idx_q + ptr_t'(1);
    assign cmp_a  = mem_q[idx_q];
    assign cmp_b  = mem_q[idx_nx];

    mag_cmp4 u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    // only gt drives the swap; lt/eq never swap, keeping the sort stable
    assign cmp_unused = cmp_lt ^ cmp_eq;
    // swap flag including the compare happening this cycle
    assign sw_now = swapped_q | cmp_gt;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = wr_ptr_q + ptr_t'(1);
                    if (wr_ptr_q == LAST) begin
                        state_d   = SORT;
                        wr_ptr_d  = '0;
                        idx_d     = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                        cnt_d     = '0;
                    end
                end
            end
            SORT: begin
                cnt_d = cnt_q + 8'd1;
                if (cmp_gt) begin
                    mem_d[idx_q]  = cmp_b;
                    mem_d[idx_nx] = cmp_a;
                end
                if (idx_q == IDX_END) begin
                    if (!sw_now || pass_q == PASS_END) begin
                        state_d  = DRAIN;
                        rd_ptr_d = '0;
                    end else begin
                        idx_d     = '0;
                        pass_d    = pass_q + 4'd1;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d     = idx_nx;
                    swapped_d = sw_now;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                    if (rd_ptr_q == LAST) begin
                        state_d  = LOAD;
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            cnt_q     <= cnt_d;
        end
    end

    // handshake outputs are held low while rst is asserted, whatever the current state
    assign in_ready  = !rst && state_q == LOAD;
    assign out_valid = !rst && state_q == DRAIN;
    assign busy      = !rst && state_q != LOAD;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign cmp_count = cnt_q;

endmodule

// File: tb/tb_cmp_sort_engine.sv
// tb_cmp_sort_engine: directed, scoreboard-based check of cmp_sort_engine at DEPTH=8 and DEPTH=2
module tb_cmp_sort_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] in_data, out_data;
    logic [7:0] cmp_count;

    logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [3:0] in_data2, out_data2;
    logic [7:0] cmp_count2;

    int         vecs = 0;
    int         errs = 0;
    logic [3:0] blk [8];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    cmp_sort_engine #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    cmp_sort_engine #(.DEPTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .busy      (busy2),
        .cmp_count (cmp_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bubble sort with early exit needs one pass per step the furthest-displaced
    // element must move left, plus one clean pass, capped at DEPTH-1 passes
    function automatic int exp_compares();
        int mx = 0;
        for (int i = 0; i < 8; i++) begin
            int c = 0;
            for (int j = 0; j < i; j++) if (blk[j] > blk[i]) c++;
            if (c > mx) mx = c;
        end
        return ((mx + 1 > 7) ? 7 : mx + 1) * 7;
    endfunction

    task automatic load_block(input bit push);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = blk[i];
            if (i == 0) check("load_in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (push)
            for (int v = 0; v < 16; v++)
                for (int i = 0; i < 8; i++)
                    if (blk[i] == 4'(v)) exp_q.push_back(4'(v));
        check("sort_busy", busy, 1);
        check("sort_in_ready", in_ready, 0);
    endtask

    task automatic run_block(input bit bp);
        int         cyc = 0;
        int         got = 0;
        int         n;
        bit         held = 0;
        logic [3:0] prev = '0;
        logic [3:0] e;
        load_block(1);
        n = exp_compares();
        // stray input during SORT must be ignored
        in_valid = 1'b1;
        in_data  = 4'hf;
        while (busy && !out_valid && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("sort_cycles", cyc, n);
        check("cmp_count", cmp_count, n);
        check("drain_valid", out_valid, 1);
        cyc = 0;
        while (got < 8 && cyc < 400) begin
            cyc++;
            if (held) check("hold_data", out_data, prev);
            if (out_valid) check("drain_in_ready", in_ready, 0);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
                got++;
            end
            held = out_valid && !out_ready;
            prev = out_data;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (got < 8) check("drain_count", got, 8);
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_out_data", out_data, 0);
        check("post_busy", busy, 0);
        check("post_cmp_count", cmp_count, n);
    endtask

    task automatic run2(input logic [3:0] x0, input logic [3:0] x1);
        logic [3:0] e;
        in_valid2 = 1'b1;
        in_data2  = x0;
        @(negedge clk);
        in_data2  = x1;
        @(negedge clk);
        in_valid2 = 1'b0;
        exp_q.push_back(x0 < x1 ? x0 : x1);
        exp_q.push_back(x0 < x1 ? x1 : x0);
        check("d2_sort_busy", busy2, 1);
        check("d2_sort_valid", out_valid2, 0);
        @(negedge clk);
        check("d2_cmp_count", cmp_count2, 1);
        out_ready2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            check("d2_valid", out_valid2, 1);
            check("d2_data", out_data2, e);
            @(negedge clk);
        end
        out_ready2 = 1'b0;
        check("d2_post_in_ready", in_ready2, 1);
        check("d2_post_valid", out_valid2, 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("init_in_ready", in_ready, 1);
        check("init_out_valid", out_valid, 0);
        check("init_out_data", out_data, 0);
        check("init_busy", busy, 0);
        check("init_cmp_count", cmp_count, 0);
        check("init_in_ready2", in_ready2, 1);

        blk = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        run_block(0);
        blk = '{4'hf, 4'he, 4'hd, 4'hc, 4'hb, 4'ha, 4'h9, 4'h8};
        run_block(0);
        blk = '{4'h9, 4'h3, 4'h9, 4'h0, 4'h3, 4'hf, 4'h0, 4'h9};
        run_block(0);
        blk = '{4'h6, 4'hc, 4'h1, 4'h6, 4'he, 4'h2, 4'h8, 4'h1};
        run_block(1);

        blk = '{4'hf, 4'he, 4'hd, 4'hc, 4'hb, 4'ha, 4'h9, 4'h8};
        load_block(0);
        repeat (9) @(negedge clk);
        check("mid_sort_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_cmp_count", cmp_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", in_ready, 1);
        check("after_rst_busy", busy, 0);
        check("after_rst_cmp_count", cmp_count, 0);
        blk = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h7, 4'h6};
        run_block(0);

        run2(4'hb, 4'ha);
        run2(4'h4, 4'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
